dram_model: RTL and testbench
=============================

// Module: dram_model
// PURPOSE
//  Cycle-level behavioural model of an external page-mode DRAM, attached to the SoC top-level DRAM pins.
//  Row address is strobed by RASn and column address by CASn, multiplexed on A.
//  Reads return one 32-bit word with VALID after a fixed CAS latency; writes have per-byte enables.
//  Storage is four byte-lane arrays Memory_byte0..3 (word-indexed), readable and preloadable by hierarchical backdoor.
// PARAMETERS
//  ROW_BITS  11  row address width; uses A[ROW_BITS-1:0]
//  COL_BITS  10  column address width; uses A[COL_BITS-1:0]
//  CAS_LAT   5   cycles from the read-command edge to VALID (>=1)
//  Word index = {row, col}; depth = 2**(ROW_BITS+COL_BITS) words.
// PORTS
//  CK     in   1   clock, all activity on rising edge
//  RSTn   in   1   asynchronous active-low reset
//  CSn    in   1   chip select, active low; when high, no command is decoded
//  RASn   in   1   row address strobe, active low
//  CASn   in   1   column address strobe, active low
//  WEn    in   4   per-byte write enable, active low; bit i -> D[8i+7:8i]
//  A      in   11  multiplexed row/column address
//  D      in   32  write data
//  Q      out  32  read data
//  VALID  out  1   one-cycle pulse marking Q valid
// BEHAVIOUR
//  Edge detection and row state
//  - Registers rasn_q and casn_q hold last-cycle RASn/CASn; they update every cycle regardless of CSn and reset to 1.
//  - RAS fall = RASn==0 && rasn_q==1. CAS fall = CASn==0 && casn_q==1.
//  - Activate: CSn==0, RAS fall, row closed -> row_reg<=A[ROW_BITS-1:0], row_open<=1.
//  - RAS fall while the row is already open is ignored; the row is kept.
//  - Precharge: CSn==0 and RASn==1 -> row_open<=0.
//  - In-flight reads still complete after precharge.
//  Column commands
//  - Accepted only when all hold: CSn==0, RASn==0, row_open==1 (from a prior edge), and CAS fall.
//  - Activate and CAS fall on the same edge: CAS is ignored.
//  - Command address = {row_reg, A[COL_BITS-1:0]}.
//  - Read (WEn==4'hF): the array word is sampled on the command edge and pushed into a CAS_LAT-deep valid/data shift pipeline.
//  - Write (any WEn bit 0): each lane i with WEn[i]==0 is written from D on that edge; other lanes are unchanged. No VALID is produced.
//  - A CAS fall with the row closed, or with CSn high, is dropped silently.
//  - Holding CASn low issues only one command; each new command needs CASn high for >=1 cycle. Maximum rate is one command per 2 cycles.
//  - Overlapping reads are allowed and leave the pipeline in issue order.
//  Outputs
//  - VALID is high exactly CAS_LAT cycles after the read-command edge, for 1 cycle.
//  - Q takes the read data in that same cycle and holds it until the next read returns.
//  - A read issued after a write to the same address returns the written data; a read issued before the write returns the old data.
//  Reset (async, RSTn low)
//  - Q=0, VALID=0, row_open=0, pipeline cleared, rasn_q=casn_q=1.
//  - Reset mid-read discards the pending data; no VALID is produced.
//  - The storage arrays are NOT cleared by reset; contents persist and may be preloaded.
//  - Out-of-range addresses cannot occur, since the address width equals the array depth.
// TESTING
//  1. Preload word 0x40000 = 0xDEADBEEF. Activate row 0x100, then CAS fall at col 0x000, WEn=F.
//     -> VALID 5 cycles later; Q=DEADBEEF.
//  2. Open row 0x100, write col 3 D=0x11223344 WEn=4'b1010, then read.
//     -> Only bytes 0 and 2 change, e.g. old 0xAABBCCDD reads back as 0xAA22CC44. Backdoor word 0x40003 matches.
//  3. Two reads to cols 1 and 2, issued 2 cycles apart.
//     -> Two VALID pulses 2 cycles apart, in order, with correct data.
//  4. CAS fall while the row is closed, or with CSn=1.
//     -> No VALID; memory unchanged.
//     CASn held low 6 cycles -> exactly one command.
//  5. Read issued, then precharge (RASn=1) next cycle.
//     -> VALID still arrives at CAS_LAT; a subsequent CAS without a new activate is ignored.
//  6. Assert RSTn low 2 cycles after a read issue.
//     -> No VALID, Q=0; preloaded memory is intact after reset.

Source files
------------

// File: rtl/dram_if.sv
// dram_if: multiplexed-address DRAM pin bundle between controller and memory
interface dram_if #(parameter int A_BITS = 11);
  logic CSn;
  logic RASn;
  logic CASn;
  logic [3:0] WEn;
  logic [A_BITS-1:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic VALID;
  modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID);
  modport slave (input CSn, RASn, CASn, WEn, A, D, output Q, VALID);
endinterface

// File: rtl/dram_model.sv
// dram_model: page-mode DRAM behavioural model with RAS/CAS strobes, byte-lane writes and fixed CAS latency
module dram_model #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int CAS_LAT = 5
) (
  input logic CK,
  input logic RSTn,
  dram_if.slave bus
);
  localparam int AW = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  logic [7:0] Memory_byte0 [DEPTH];
  logic [7:0] Memory_byte1 [DEPTH];
  logic [7:0] Memory_byte2 [DEPTH];
  logic [7:0] Memory_byte3 [DEPTH];
  logic rasn_q, casn_q, row_open;
  logic [ROW_BITS-1:0] row_reg;
  logic cmd, rd_cmd, wr_cmd;
  logic [AW-1:0] addr;
  logic [31:0] rd_word;
  logic [CAS_LAT-1:0] vld_sh;
  logic [31:0] dat_sh [CAS_LAT];
  // row_open is the pre-edge value, so a CAS on the activate edge is ignored
  always_comb begin
    cmd = !bus.CSn && !bus.RASn && row_open && !bus.CASn && casn_q;
    rd_cmd = cmd && (&bus.WEn);
    wr_cmd = cmd && !(&bus.WEn);
    addr = {row_reg, bus.A[COL_BITS-1:0]};
    rd_word = {Memory_byte3[addr], Memory_byte2[addr], Memory_byte1[addr], Memory_byte0[addr]};
  end
  always_ff @(posedge CK or negedge RSTn)
    if (!RSTn) begin
      rasn_q <= 1'b1;
      casn_q <= 1'b1;
      row_open <= 1'b0;
      row_reg <= '0;
    end else begin
      rasn_q <= bus.RASn;
      casn_q <= bus.CASn;
      if (!bus.CSn && bus.RASn) row_open <= 1'b0;
      else if (!bus.CSn && rasn_q && !row_open) begin
        row_reg <= bus.A[ROW_BITS-1:0];
        row_open <= 1'b1;
      end
    end
  // Q/VALID form the stage after the shift line, landing CAS_LAT edges after the command
  always_ff @(posedge CK or negedge RSTn)
    if (!RSTn) begin
      vld_sh <= '0;
      for (int i = 0; i < CAS_LAT; i++) dat_sh[i] <= '0;
      bus.VALID <= 1'b0;
      bus.Q <= '0;
    end else begin
      for (int i = CAS_LAT - 1; i > 0; i--) begin
        vld_sh[i] <= vld_sh[i-1];
        dat_sh[i] <= dat_sh[i-1];
      end
      vld_sh[0] <= rd_cmd;
      dat_sh[0] <= rd_word;
      bus.VALID <= vld_sh[CAS_LAT-1];
      if (vld_sh[CAS_LAT-1]) bus.Q <= dat_sh[CAS_LAT-1];
    end
  // storage is deliberately outside reset so preloaded contents survive it
  always @(posedge CK)
    if (wr_cmd) begin
      if (!bus.WEn[0]) Memory_byte0[addr] <= bus.D[7:0];
      if (!bus.WEn[1]) Memory_byte1[addr] <= bus.D[15:8];
      if (!bus.WEn[2]) Memory_byte2[addr] <= bus.D[23:16];
      if (!bus.WEn[3]) Memory_byte3[addr] <= bus.D[31:24];
    end
endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: scoreboard bench for dram_model read latency, byte writes, command filtering and reset
module tb_dram_model;
  localparam int CAS_LAT = 5;
  typedef struct {
    logic [31:0] d;
    int due;
  } exp_t;
  logic CK = 1'b0;
  logic RSTn = 1'b0;
  dram_if #(.A_BITS(11)) bus ();
  dram_model #(.ROW_BITS(11), .COL_BITS(10), .CAS_LAT(CAS_LAT)) dut (.CK(CK), .RSTn(RSTn), .bus(bus));
  always #5 CK = ~CK;
  exp_t sb[$];
  logic [31:0] model [int];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  logic [10:0] cur_row = '0;
  always @(posedge CK) cyc <= cyc + 1;
  always @(negedge CK)
    if (bus.VALID === 1'b1) begin
      exp_t e;
      valid_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d Q=%h required no VALID", cyc, bus.Q);
      end else begin
        e = sb.pop_front();
        if (bus.Q !== e.d || cyc !== e.due) begin
          n_fail++;
          $display("FAIL read_return got Q=%h cyc=%0d required Q=%h cyc=%0d", bus.Q, cyc, e.d, e.due);
        end
      end
    end
  function automatic logic [31:0] bd(input int a);
    return {dut.Memory_byte3[a], dut.Memory_byte2[a], dut.Memory_byte1[a], dut.Memory_byte0[a]};
  endfunction
  task automatic preload(input int a, input logic [31:0] v);
    dut.Memory_byte0[a] = v[7:0];
    dut.Memory_byte1[a] = v[15:8];
    dut.Memory_byte2[a] = v[23:16];
    dut.Memory_byte3[a] = v[31:24];
    model[a] = v;
  endtask
  task automatic drv(input logic cs, input logic ras, input logic cas, input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
    @(negedge CK);
    bus.CSn = cs;
    bus.RASn = ras;
    bus.CASn = cas;
    bus.WEn = we;
    bus.A = a;
    bus.D = d;
  endtask
  task automatic activate(input logic [10:0] row);
    drv(1'b0, 1'b1, 1'b1, 4'hF, '0, '0);
    drv(1'b0, 1'b0, 1'b1, 4'hF, row, '0);
    cur_row = row;
  endtask
  task automatic rd(input logic [9:0] col);
    int a;
    a = int'({cur_row, col});
    drv(1'b0, 1'b0, 1'b0, 4'hF, {1'b0, col}, '0);
    sb.push_back('{d: model[a], due: cyc + 1 + CAS_LAT});
    drv(1'b0, 1'b0, 1'b1, 4'hF, {1'b0, col}, '0);
  endtask
  task automatic wr(input logic [9:0] col, input logic [31:0] d, input logic [3:0] we);
    int a;
    logic [31:0] v;
    a = int'({cur_row, col});
    v = model[a];
    for (int i = 0; i < 4; i++) if (!we[i]) v[8*i+:8] = d[8*i+:8];
    model[a] = v;
    drv(1'b0, 1'b0, 1'b0, we, {1'b0, col}, d);
    drv(1'b0, 1'b0, 1'b1, 4'hF, {1'b0, col}, '0);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CK);
    repeat (2) @(negedge CK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge CK);
    n_checks++;
    if (bus.Q !== 32'h0 || bus.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs Q=%h VALID=%b required 0/0", bus.Q, bus.VALID);
    end
    RSTn = 1'b1;
    @(negedge CK);
  endtask
  task automatic test_basic_read;
    preload(32'h40000, 32'hDEADBEEF);
    activate(11'h100);
    rd(10'h000);
    drain("basic_read");
    n_checks++;
    if (bus.Q !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_read_hold Q=%h required DEADBEEF", bus.Q);
    end
  endtask
  task automatic test_byte_write;
    preload(32'h40003, 32'hAABBCCDD);
    preload(32'h40005, 32'h55555555);
    wr(10'h003, 32'h11223344, 4'b1010);
    n_checks++;
    if (bd(32'h40003) !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL byte_write_backdoor got=%h required AA22CC44", bd(32'h40003));
    end
    rd(10'h003);
    rd(10'h005);
    wr(10'h005, 32'h00000000, 4'b0000);
    rd(10'h005);
    drain("byte_write");
  endtask
  task automatic test_back_to_back;
    preload(32'h40001, 32'h01020304);
    preload(32'h40002, 32'hA0B0C0D0);
    rd(10'h001);
    rd(10'h002);
    drain("back_to_back");
  endtask
  task automatic test_dropped;
    int v0;
    v0 = valid_cnt;
    drv(1'b0, 1'b1, 1'b1, 4'hF, '0, '0);
    drv(1'b0, 1'b1, 1'b0, 4'h0, '0, 32'hFFFFFFFF);
    drv(1'b1, 1'b0, 1'b1, 4'hF, 11'h100, '0);
    drv(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'hFFFFFFFF);
    drv(1'b0, 1'b0, 1'b1, 4'hF, '0, '0);
    drv(1'b0, 1'b0, 1'b0, 4'hF, '0, '0);
    drv(1'b0, 1'b0, 1'b1, 4'hF, '0, '0);
    n_checks++;
    if (bd(32'h40000) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL closed_row_write got=%h required DEADBEEF", bd(32'h40000));
    end
    activate(11'h100);
    drv(1'b1, 1'b0, 1'b0, 4'h0, '0, 32'h12345678);
    drv(1'b0, 1'b0, 1'b1, 4'hF, '0, '0);
    n_checks++;
    if (bd(32'h40000) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL csn_high_write got=%h required DEADBEEF", bd(32'h40000));
    end
    repeat (CAS_LAT + 3) @(negedge CK);
    n_checks++;
    if (valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL dropped_valid count=%0d required %0d", valid_cnt - v0, 0);
    end
    v0 = valid_cnt;
    drv(1'b0, 1'b0, 1'b0, 4'hF, 11'h001, '0);
    sb.push_back('{d: model[32'h40001], due: cyc + 1 + CAS_LAT});
    repeat (5) drv(1'b0, 1'b0, 1'b0, 4'hF, 11'h001, '0);
    drv(1'b0, 1'b0, 1'b1, 4'hF, 11'h001, '0);
    drain("cas_held");
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL cas_held_count got=%0d required 1", valid_cnt - v0);
    end
  endtask
  task automatic test_precharge;
    int v0;
    rd(10'h002);
    drv(1'b0, 1'b1, 1'b1, 4'hF, '0, '0);
    drv(1'b1, 1'b0, 1'b1, 4'hF, 11'h100, '0);
    drv(1'b0, 1'b0, 1'b0, 4'hF, 11'h001, '0);
    drv(1'b0, 1'b0, 1'b1, 4'hF, 11'h001, '0);
    drain("precharge");
    v0 = valid_cnt;
    repeat (CAS_LAT + 2) @(negedge CK);
    n_checks++;
    if (valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL precharge_ignored count=%0d required 0", valid_cnt - v0);
    end
  endtask
  task automatic test_reset_mid_read;
    int v0;
    activate(11'h100);
    rd(10'h000);
    drv(1'b0, 1'b0, 1'b1, 4'hF, '0, '0);
    v0 = valid_cnt;
    @(negedge CK);
    RSTn = 1'b0;
    sb.delete();
    drv(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
    @(negedge CK);
    n_checks++;
    if (bus.Q !== 32'h0 || bus.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_reset Q=%h VALID=%b required 0/0", bus.Q, bus.VALID);
    end
    RSTn = 1'b1;
    repeat (CAS_LAT + 4) @(negedge CK);
    n_checks++;
    if (valid_cnt !== v0 || bus.Q !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_read_flush valids=%0d Q=%h required 0 valids Q=0", valid_cnt - v0, bus.Q);
    end
    n_checks++;
    if (bd(32'h40000) !== 32'hDEADBEEF || bd(32'h40003) !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL memory_persist got=%h/%h required DEADBEEF/AA22CC44", bd(32'h40000), bd(32'h40003));
    end
  endtask
  initial begin
    bus.CSn = 1'b1;
    bus.RASn = 1'b1;
    bus.CASn = 1'b1;
    bus.WEn = 4'hF;
    bus.A = '0;
    bus.D = '0;
    test_reset;
    test_basic_read;
    test_byte_write;
    test_back_to_back;
    test_dropped;
    test_precharge;
    test_reset_mid_read;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
